// File: rtl/spi_slave_responder.sv
// SPI slave responder: synchronises an external master's sclk/ss_n/mosi onto
// PCLK, receives one DATA_W-bit frame per transfer and shifts out a frame
// taken from a single-entry TX buffer on miso.
module spi_slave_responder #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              PCLK,
  input  logic              PRESET_n,
  input  logic              spe_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsbfe_i,
  input  logic              sclk_i,
  input  logic              ss_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_load_i,
  output logic              tx_empty_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_read_i,
  output logic              overrun_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         bit_cnt;
  logic                     rx_full;
  logic [DATA_W-1:0]        tx_buf;
  logic [DATA_W-1:0]        tx_shift;
  logic [DATA_W-1:0]        rx_shift;

  logic [SYNC_STAGES-1:0]   sclk_sync;
  logic [SYNC_STAGES-1:0]   ss_sync;
  logic [SYNC_STAGES-1:0]   mosi_sync;
  logic                     sclk_p1;
  logic                     ss_p1;

  logic                     sclk_s;
  logic                     ss_s;
  logic                     mosi_s;
  logic                     sclk_rise;
  logic                     sclk_fall;
  logic                     lead_edge;
  logic                     trail_edge;
  logic                     sample_edge;
  logic                     shift_edge;
  logic                     ss_fall;
  logic                     abort;
  logic                     start_go;
  logic                     complete_go;
  logic                     sample_go;
  logic                     shift_go;
  logic [DATA_W-1:0]        tx_word;

  // Bit currently at the head of a frame in the selected bit order.
  function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb_first);
    return lsb_first ? w[0] : w[DATA_W-1];
  endfunction

  // Frame with its head bit consumed.
  function automatic logic [DATA_W-1:0] drop_head(input logic [DATA_W-1:0] w, input logic lsb_first);
    return lsb_first ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  // Append a received bit so that the first bit lands at its frame position.
  function automatic logic [DATA_W-1:0] push_bit(input logic [DATA_W-1:0] w, input logic b,
                                                 input logic lsb_first);
    return lsb_first ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sclk_rise   = sclk_s & ~sclk_p1;
  assign sclk_fall   = ~sclk_s & sclk_p1;
  assign lead_edge   = cpol_i ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_i ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_i ? trail_edge : lead_edge;
  assign shift_edge  = cpha_i ? lead_edge : trail_edge;
  assign ss_fall     = ss_p1 & ~ss_s;

  // An empty buffer shifts out all ones so the master sees an idle-high line.
  assign tx_word = tx_empty_o ? '1 : tx_buf;

  assign abort       = (state == ACTIVE) && (!spe_i || ss_s);
  assign start_go    = (state == IDLE) && spe_i && ss_fall;
  assign complete_go = (state == ACTIVE) && !abort && (bit_cnt == CNT_W'(DATA_W));
  assign sample_go   = (state == ACTIVE) && !abort && !complete_go && sample_edge;
  assign shift_go    = (state == ACTIVE) && !abort && !complete_go && shift_edge;

  assign busy_o = (state == ACTIVE);

  // Stage p0: synchronisers; stage p1: delayed copies for edge detection.
  always_ff @(posedge PCLK) begin
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
    ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n_i};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
    sclk_p1   <= sclk_s;
    ss_p1     <= ss_s;
  end

  // Shift registers and TX buffer contents; validity is tracked by the control block.
  always_ff @(posedge PCLK) begin
    if (start_go || complete_go) begin
      // With cpha=0 the head bit goes out at select time, so it is consumed here.
      tx_shift <= (start_go && !cpha_i) ? drop_head(tx_word, lsbfe_i) : tx_word;
    end else if (shift_go) begin
      tx_shift <= drop_head(tx_shift, lsbfe_i);
    end
    if (sample_go) begin
      rx_shift <= push_bit(rx_shift, mosi_s, lsbfe_i);
    end
    if (tx_load_i && tx_empty_o) begin
      tx_buf <= tx_data_i;
    end
  end

  // Transfer FSM plus TX/RX handshake state and registered outputs.
  always_ff @(posedge PCLK) begin
    if (!PRESET_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      miso_o     <= 1'b0;
      miso_oe_o  <= 1'b0;
      tx_empty_o <= 1'b1;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      rx_full    <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      miso_oe_o  <= spe_i & ~ss_s;

      // A load coinciding with a reload refills the buffer for the next frame.
      if (tx_load_i && tx_empty_o) begin
        tx_empty_o <= 1'b0;
      end else if (start_go || complete_go) begin
        tx_empty_o <= 1'b1;
      end

      // A host read in the completion cycle frees room for the new frame.
      if (complete_go) begin
        if (!rx_full || rx_read_i) begin
          rx_data_o  <= rx_shift;
          rx_valid_o <= 1'b1;
          rx_full    <= 1'b1;
          if (rx_read_i) begin
            overrun_o <= 1'b0;
          end
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (rx_read_i) begin
        rx_full   <= 1'b0;
        overrun_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          miso_o  <= 1'b0;
          bit_cnt <= '0;
          if (start_go) begin
            state <= ACTIVE;
            if (!cpha_i) begin
              miso_o <= head_bit(tx_word, lsbfe_i);
            end
          end
        end
        ACTIVE: begin
          if (abort) begin
            state   <= IDLE;
            bit_cnt <= '0;
            miso_o  <= 1'b0;
          end else if (complete_go) begin
            bit_cnt <= '0;
          end else begin
            if (sample_go) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (shift_go) begin
              miso_o <= head_bit(tx_shift, lsbfe_i);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Testbench for spi_slave_responder: acts as the SPI master and host, and
// checks the slave against a frame-level model of the TX buffer and RX side.
module tb_spi_slave_responder;

  localparam int DATA_W = 8;
  localparam int H      = 4;  // sclk half period in PCLK cycles

  logic              PCLK = 1'b0;
  logic              PRESET_n = 1'b1;
  logic              spe_i = 1'b1;
  logic              cpol_i = 1'b0;
  logic              cpha_i = 1'b0;
  logic              lsbfe_i = 1'b0;
  logic              sclk_i = 1'b0;
  logic              ss_n_i = 1'b1;
  logic              mosi_i = 1'b0;
  logic              miso_o;
  logic              miso_oe_o;
  logic [DATA_W-1:0] tx_data_i = '0;
  logic              tx_load_i = 1'b0;
  logic              tx_empty_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              rx_read_i = 1'b0;
  logic              overrun_o;
  logic              busy_o;

  spi_slave_responder #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .PCLK(PCLK), .PRESET_n(PRESET_n), .spe_i(spe_i), .cpol_i(cpol_i), .cpha_i(cpha_i),
    .lsbfe_i(lsbfe_i), .sclk_i(sclk_i), .ss_n_i(ss_n_i), .mosi_i(mosi_i), .miso_o(miso_o),
    .miso_oe_o(miso_oe_o), .tx_data_i(tx_data_i), .tx_load_i(tx_load_i),
    .tx_empty_o(tx_empty_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .rx_read_i(rx_read_i), .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  always @(negedge PCLK) if (rx_valid_o === 1'b1) pulses++;

  // Frame-level reference model
  bit                m_tx_full = 0;
  logic [DATA_W-1:0] m_tx_val = '0;
  logic [DATA_W-1:0] m_cur = '1;
  bit                m_rx_full = 0;
  logic [DATA_W-1:0] m_rx_data = '0;
  bit                m_ovr = 0;
  int                m_pulses = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic model_take();
    m_cur = m_tx_full ? m_tx_val : '1;
    m_tx_full = 0;
  endtask

  task automatic model_complete(input logic [DATA_W-1:0] w);
    if (!m_rx_full) begin
      m_rx_data = w;
      m_rx_full = 1;
      m_pulses++;
    end else begin
      m_ovr = 1;
    end
    model_take();
  endtask

  task automatic do_reset(input int n);
    PRESET_n = 1'b0;
    tick(n);
    PRESET_n = 1'b1;
    m_tx_full = 0;
    m_rx_full = 0;
    m_ovr = 0;
    m_rx_data = '0;
  endtask

  task automatic load_tx(input logic [DATA_W-1:0] v);
    if (!m_tx_full) begin
      m_tx_val = v;
      m_tx_full = 1;
    end
    tx_data_i = v;
    tx_load_i = 1'b1;
    tick(1);
    tx_load_i = 1'b0;
  endtask

  task automatic host_read();
    rx_read_i = 1'b1;
    tick(1);
    rx_read_i = 1'b0;
    m_rx_full = 0;
    m_ovr = 0;
  endtask

  task automatic set_mode(input logic cpol, input logic cpha, input logic lsb);
    cpol_i = cpol;
    cpha_i = cpha;
    lsbfe_i = lsb;
    sclk_i = cpol;
    tick(4);
  endtask

  task automatic begin_sel();
    ss_n_i = 1'b0;
    tick(8);
    if (spe_i) model_take();
  endtask

  task automatic end_sel();
    ss_n_i = 1'b1;
    tick(6);
  endtask

  // Master side of one frame (or nbits of it); returns miso bits in frame positions.
  task automatic xfer(input logic [DATA_W-1:0] mo, input int nbits, output logic [DATA_W-1:0] mi);
    int idx;
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = lsbfe_i ? i : DATA_W - 1 - i;
      if (!cpha_i) begin
        mosi_i = mo[idx];
        tick(H);
        mi[idx] = miso_o;
        sclk_i = ~sclk_i;
        tick(H);
        sclk_i = ~sclk_i;
      end else begin
        sclk_i = ~sclk_i;
        mosi_i = mo[idx];
        tick(H);
        mi[idx] = miso_o;
        sclk_i = ~sclk_i;
        tick(H);
      end
    end
    tick(H + 2);
    if (nbits == DATA_W) model_complete(mo);
  endtask

  task automatic test_reset();
    do_reset(3);
    total++;
    if ({miso_o, miso_oe_o, tx_empty_o, rx_valid_o, overrun_o, busy_o} !== 6'b001000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 001000",
               {miso_o, miso_oe_o, tx_empty_o, rx_valid_o, overrun_o, busy_o});
    end
    total++;
    if (rx_data_o !== 8'h00) begin
      bad++;
      $display("FAIL reset_rx_data: got %h want 00", rx_data_o);
    end
  endtask

  task automatic test_disabled();
    spe_i = 1'b0;
    set_mode(0, 0, 0);
    begin_sel();
    total++;
    if ({busy_o, miso_oe_o} !== 2'b00) begin
      bad++;
      $display("FAIL disabled_idle: got busy/oe %b want 00", {busy_o, miso_oe_o});
    end
    end_sel();
    spe_i = 1'b1;
    tick(2);
  endtask

  task automatic test_mode0_msb();
    logic [DATA_W-1:0] mi;
    int p0;
    set_mode(0, 0, 0);
    load_tx(8'hA5);
    total++;
    if (tx_empty_o !== 1'b0) begin
      bad++;
      $display("FAIL m0_tx_loaded: got tx_empty %b want 0", tx_empty_o);
    end
    begin_sel();
    total++;
    if ({busy_o, miso_oe_o, tx_empty_o} !== 3'b111) begin
      bad++;
      $display("FAIL m0_selected: got busy/oe/empty %b want 111", {busy_o, miso_oe_o, tx_empty_o});
    end
    p0 = pulses;
    xfer(8'h3C, 8, mi);
    total++;
    if (mi !== 8'hA5) begin
      bad++;
      $display("FAIL m0_miso: got %h want a5", mi);
    end
    total++;
    if (rx_data_o !== 8'h3C || pulses - p0 != 1) begin
      bad++;
      $display("FAIL m0_rx: got %h pulses %0d want 3c pulses 1", rx_data_o, pulses - p0);
    end
    end_sel();
    total++;
    if ({busy_o, miso_o, miso_oe_o} !== 3'b000) begin
      bad++;
      $display("FAIL m0_deselect: got busy/miso/oe %b want 000", {busy_o, miso_o, miso_oe_o});
    end
    host_read();
  endtask

  task automatic test_mode3_lsb();
    logic [DATA_W-1:0] mi;
    set_mode(1, 1, 1);
    load_tx(8'h81);
    begin_sel();
    xfer(8'h0F, 8, mi);
    total++;
    if (mi !== 8'h81) begin
      bad++;
      $display("FAIL m3_miso: got %h want 81", mi);
    end
    total++;
    if (rx_data_o !== 8'h0F) begin
      bad++;
      $display("FAIL m3_rx: got %h want 0f", rx_data_o);
    end
    end_sel();
    host_read();
  endtask

  task automatic test_no_load_mode1();
    logic [DATA_W-1:0] mi;
    logic [DATA_W-1:0] mo;
    mo = DATA_W'($urandom);
    set_mode(0, 1, 0);
    begin_sel();
    xfer(mo, 8, mi);
    total++;
    if (mi !== 8'hFF || tx_empty_o !== 1'b1) begin
      bad++;
      $display("FAIL m1_empty: got miso %h empty %b want ff 1", mi, tx_empty_o);
    end
    total++;
    if (rx_data_o !== mo) begin
      bad++;
      $display("FAIL m1_rx: got %h want %h", rx_data_o, mo);
    end
    end_sel();
    host_read();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] mi;
    int p0;
    set_mode(0, 0, 0);
    p0 = pulses;
    begin_sel();
    xfer(8'h11, 8, mi);
    xfer(8'h22, 8, mi);
    end_sel();
    total++;
    if (rx_data_o !== 8'h11 || overrun_o !== 1'b1 || pulses - p0 != 1) begin
      bad++;
      $display("FAIL b2b_overrun: got rx %h ovr %b pulses %0d want 11 1 1",
               rx_data_o, overrun_o, pulses - p0);
    end
    host_read();
    total++;
    if (overrun_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_clear: got ovr %b want 0", overrun_o);
    end
  endtask

  task automatic test_abort();
    logic [DATA_W-1:0] mi;
    int p0;
    set_mode(1, 0, 0);
    p0 = pulses;
    begin_sel();
    xfer(DATA_W'($urandom), 5, mi);
    end_sel();
    total++;
    if (pulses != p0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL abort_nopulse: got pulses %0d busy %b want 0 0", pulses - p0, busy_o);
    end
    begin_sel();
    xfer(8'h5A, 8, mi);
    end_sel();
    total++;
    if (rx_data_o !== 8'h5A || pulses - p0 != 1) begin
      bad++;
      $display("FAIL abort_next: got rx %h pulses %0d want 5a 1", rx_data_o, pulses - p0);
    end
    host_read();
  endtask

  task automatic test_reset_mid_frame();
    logic [DATA_W-1:0] mi;
    int p0;
    set_mode(0, 0, 0);
    load_tx(8'hC3);
    begin_sel();
    xfer(DATA_W'($urandom), 4, mi);
    p0 = pulses;
    do_reset(1);
    total++;
    if ({miso_o, miso_oe_o, tx_empty_o, rx_valid_o, overrun_o, busy_o} !== 6'b001000
        || rx_data_o !== 8'h00) begin
      bad++;
      $display("FAIL midreset_state: got %b rx %h want 001000 00",
               {miso_o, miso_oe_o, tx_empty_o, rx_valid_o, overrun_o, busy_o}, rx_data_o);
    end
    end_sel();
    begin_sel();
    xfer(8'h96, 8, mi);
    end_sel();
    total++;
    if (rx_data_o !== 8'h96 || mi !== 8'hFF || pulses - p0 != 1) begin
      bad++;
      $display("FAIL midreset_next: got rx %h miso %h pulses %0d want 96 ff 1",
               rx_data_o, mi, pulses - p0);
    end
    host_read();
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] mi;
    logic [DATA_W-1:0] mo;
    logic [DATA_W-1:0] exp_mi;
    int nf;
    for (int it = 0; it < 12; it++) begin
      set_mode(1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(1, 0) == 1) load_tx(DATA_W'($urandom));
      if ($urandom_range(2, 0) == 0) host_read();
      nf = $urandom_range(3, 1);
      begin_sel();
      for (int f = 0; f < nf; f++) begin
        exp_mi = m_cur;
        mo = DATA_W'($urandom);
        xfer(mo, 8, mi);
        total++;
        if (mi !== exp_mi) begin
          bad++;
          $display("FAIL rand_miso[%0d.%0d]: got %h want %h", it, f, mi, exp_mi);
        end
        total++;
        if (rx_data_o !== m_rx_data || overrun_o !== m_ovr || pulses != m_pulses) begin
          bad++;
          $display("FAIL rand_rx[%0d.%0d]: got rx %h ovr %b pulses %0d want %h %b %0d",
                   it, f, rx_data_o, overrun_o, pulses, m_rx_data, m_ovr, m_pulses);
        end
      end
      end_sel();
      total++;
      if (tx_empty_o !== !m_tx_full) begin
        bad++;
        $display("FAIL rand_tx_empty[%0d]: got %b want %b", it, tx_empty_o, !m_tx_full);
      end
    end
  endtask

  initial begin
    test_reset();
    test_disabled();
    test_mode0_msb();
    test_mode3_lsb();
    test_no_load_mode1();
    test_back_to_back();
    test_abort();
    test_reset_mid_frame();
    m_pulses = pulses;
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
